// File: rtl/clock_cfg_pkg.sv
// clock_cfg_pkg: shared widths, reset defaults and FSM state type for clock_cfg_ctrl
package clock_cfg_pkg;
    localparam int PER_W = 4;
    localparam int DUTY_W = 2;
    localparam int NUM_CH = 4;
    localparam int CH_W = 2;
    localparam logic [PER_W-1:0] DEF_PERIOD = 4'd8;
    localparam logic [DUTY_W-1:0] DEF_DUTY = 2'd2;
    localparam int DEF_TIMEOUT = 32;
    typedef enum logic {IDLE, WAIT_EDGE} state_t;
endpackage

// File: rtl/clk_edge_det.sv
// clk_edge_det: registered rising-edge detector for the clock-bank feedback
// ports: clk, rst_n (async, active-low); clk_fb[N] feedback in; rise[N] one-cycle rising-edge flags out
module clk_edge_det #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] clk_fb,
    output logic [N-1:0] rise
);
    logic [N-1:0] fb_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fb_q <= '0;
        else fb_q <= clk_fb;
    assign rise = clk_fb & ~fb_q;
endmodule

// File: rtl/clock_cfg_ctrl.sv
// clock_cfg_ctrl: staged/immediate, glitch-safe period/duty configuration for four clock generators
// ports: clk, rst_n (async, active-low);
//   wr_valid/wr_ready/wr_ch/wr_period/wr_duty/wr_stage  per-channel write handshake;
//   commit_valid/commit_ready  apply all staged channels;
//   clk_fb  registered feedback of clk0..clk3;
//   period_out/duty_out  active settings to the bank; pending  staged-not-applied flags;
//   busy  waiting for an edge; timeout_err/err_clr  sticky forced-update flag and its clear
module clock_cfg_ctrl
    import clock_cfg_pkg::*;
#(
    parameter logic [PER_W-1:0]  RESET_PERIOD = DEF_PERIOD,
    parameter logic [DUTY_W-1:0] RESET_DUTY   = DEF_DUTY,
    parameter int                TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [CH_W-1:0]            wr_ch,
    input  logic [PER_W-1:0]           wr_period,
    input  logic [DUTY_W-1:0]          wr_duty,
    input  logic                       wr_stage,
    input  logic                       commit_valid,
    output logic                       commit_ready,
    input  logic [NUM_CH-1:0]          clk_fb,
    output logic [NUM_CH*PER_W-1:0]    period_out,
    output logic [NUM_CH*DUTY_W-1:0]   duty_out,
    output logic [NUM_CH-1:0]          pending,
    output logic                       busy,
    output logic                       timeout_err,
    input  logic                       err_clr
);
    localparam int CW = $clog2(TIMEOUT);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [NUM_CH-1:0] rise;
    logic [CH_W-1:0] req_ch;
    logic [PER_W-1:0] req_per;
    logic [DUTY_W-1:0] req_duty;
    logic [NUM_CH-1:0][PER_W-1:0] sh_per, act_per;
    logic [NUM_CH-1:0][DUTY_W-1:0] sh_duty, act_duty;
    logic commit_acc, wr_acc, hit, expire, apply, forced;

    clk_edge_det #(.N(NUM_CH)) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_fb (clk_fb),
        .rise   (rise)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // commit outranks a simultaneous write; the write is simply held off a cycle
    always_comb begin
        commit_ready = state == IDLE;
        wr_ready = commit_ready && !commit_valid;
        commit_acc = commit_ready && commit_valid;
        wr_acc = wr_ready && wr_valid;
        hit = rise[req_ch];
        expire = cnt == CW'(TIMEOUT - 1);
        apply = state == WAIT_EDGE && (hit || expire);
        forced = apply && !hit;
        state_nx = wr_acc && !wr_stage ? WAIT_EDGE : apply ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sh_per <= {NUM_CH{RESET_PERIOD}};
            sh_duty <= {NUM_CH{RESET_DUTY}};
            act_per <= {NUM_CH{RESET_PERIOD}};
            act_duty <= {NUM_CH{RESET_DUTY}};
            pending <= '0;
            cnt <= '0;
            req_ch <= '0;
            req_per <= '0;
            req_duty <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (commit_acc) begin
                for (int i = 0; i < NUM_CH; i++)
                    if (pending[i]) begin
                        act_per[i] <= sh_per[i];
                        act_duty[i] <= sh_duty[i];
                    end
                pending <= '0;
            end
            if (wr_acc) begin
                sh_per[wr_ch] <= wr_period;
                sh_duty[wr_ch] <= wr_duty;
                pending[wr_ch] <= wr_stage;
            end
            if (wr_acc && !wr_stage) begin
                req_ch <= wr_ch;
                req_per <= wr_period;
                req_duty <= wr_duty;
                cnt <= '0;
            end else if (state == WAIT_EDGE)
                cnt <= cnt + 1'b1;
            if (apply) begin
                act_per[req_ch] <= req_per;
                act_duty[req_ch] <= req_duty;
            end
            // a forced update in the same cycle as err_clr keeps the flag set
            timeout_err <= forced || (timeout_err && !err_clr);
        end

    assign period_out = act_per;
    assign duty_out = act_duty;
    assign busy = state != IDLE;
endmodule

// File: doc/clock_cfg_ctrl.md
Name: clock_cfg_ctrl

Overview:
- Configuration controller for the bank of four programmable clock generators (`clk0..clk3`), each driven by a 4-bit `period` and 2-bit `duty` word.
- Accepts per-channel write requests over a valid/ready handshake and holds staged (shadow) and active settings.
- Applies new settings glitch-safely: either on the target channel's next rising output edge, or for all staged channels at once on a commit.
- Sits between the host/config logic and the clock bank; its active outputs drive the bank's `period`/`duty` inputs directly.

Parameters:
- RESET_PERIOD, 4'd8, period value loaded into every channel at reset.
- RESET_DUTY, 2'd2, duty value loaded into every channel at reset.
- TIMEOUT, 32, cycles to wait for a target-channel rising edge before forcing the update (must be ≥2).

Ports:
- clk  in  1  system clock; also clocks the clock bank.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_ch  in  2  target channel 0..3.
- wr_period  in  4  new period.
- wr_duty  in  2  new duty.
- wr_stage  in  1  1 = stage only (shadow), 0 = immediate edge-aligned apply.
- commit_valid  in  1  request to apply all staged channels.
- commit_ready  out  1  commit accepted when commit_valid && commit_ready.
- clk_fb  in  4  feedback of clk0..clk3; generated synchronously from clk, registered.
- period_out  out  16  active periods, ch i at [4i+3:4i].
- duty_out  out  8  active duties, ch i at [2i+1:2i].
- pending  out  4  per-channel staged-not-applied flags.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set when an update was forced by timeout.
- err_clr  in  1  clears timeout_err.

Behaviour:
- **Reset (async, rst_n=0):**
  - all active and shadow regs = RESET_PERIOD / RESET_DUTY;
  - pending=0, state=IDLE, timeout_err=0, counter=0, edge-detect regs=0.
  - Applies immediately, including mid-WAIT_EDGE; the in-flight write is discarded.
- **Edge detect:** fb_q <= clk_fb each cycle; rise[i] = clk_fb[i] & ~fb_q[i] (combinational).
- **FSM states:** IDLE, WAIT_EDGE.
- **Handshake outputs:**
  - commit_ready = (state==IDLE).
  - wr_ready = (state==IDLE) && !commit_valid; a commit has priority when both are presented.
- **IDLE, commit accepted:**
  - for each i with pending[i]: active[i] <= shadow[i];
  - pending <= 0; stay IDLE.
  - Outputs change on the accepting edge. A commit with pending=0 is a no-op but is still accepted.
- **IDLE, write accepted, wr_stage=1:**
  - shadow[wr_ch] <= {wr_period, wr_duty}; pending[wr_ch] <= 1; stay IDLE.
  - Back-to-back stage writes are accepted every cycle; a rewrite of the same channel overwrites its shadow.
- **IDLE, write accepted, wr_stage=0:**
  - latch ch/period/duty into the request reg;
  - shadow[wr_ch] <= new value; pending[wr_ch] <= 0; counter <= 0; go WAIT_EDGE.
- **WAIT_EDGE:**
  - wr_ready=0, commit_ready=0; counter increments each cycle.
  - If rise[ch]: active[ch] <= req at that edge; go IDLE.
  - Else if counter==TIMEOUT-1: active[ch] <= req; timeout_err <= 1; go IDLE.
- **Latency:**
  - Edge-aligned update lands on the same clk edge at which clk_fb[ch] is first seen high. Minimum 1 cycle after acceptance.
  - Forced update lands on the TIMEOUT-th edge after acceptance.
- **timeout_err:** err_clr clears it. If a set and a clear occur in the same cycle, the set wins.
- **Value handling:** period/duty values pass through unchanged, with no clamping or validation. Only the addressed channel's active fields ever change in a single-channel update.

Decomposition:
- Package clock_cfg_pkg: PER_W=4, DUTY_W=2, NUM_CH=4, state enum {IDLE, WAIT_EDGE}, reset-default constants.
- One sub-module, clk_edge_det: a NUM_CH-wide registered rising-edge detector (clk, rst_n, clk_fb → rise).

Test Plan:
1. **Reset:** release rst_n → period_out=16'h8888, duty_out=8'hAA, pending=0, busy=0, timeout_err=0. Assert rst_n low mid-run → same values immediately, without waiting for a clk edge.
2. **Stage + commit:**
   - Stage ch1={3,1} and ch3={15,0} → pending=4'b1010, outputs unchanged.
   - Commit → period_out=16'hF838, duty_out=8'h26, pending=0 on the accepting edge.
3. **Immediate apply:** write ch2={5,3}, wr_stage=0; clk_fb[2] rises 7 cycles later → busy=1 for 7 cycles; period_out[11:8]=5 and duty_out[5:4]=3 exactly on the rise edge; other channels unchanged.
4. **Timeout:** write ch0={2,1}, clk_fb held at 0 → apply on the 32nd edge after acceptance, timeout_err=1; pulse err_clr → 0.
5. **Arbitration:** assert commit_valid and wr_valid together in IDLE → commit accepted, wr_ready=0 that cycle; write accepted the next cycle. During WAIT_EDGE, both readies stay 0.
6. **Reset during WAIT_EDGE:** assert rst_n low 3 cycles into the wait, then deassert → the request is gone and a later clk_fb rise changes nothing; outputs stay at defaults.
